// File: rtl/soc_ram_sp2_ctl_if.sv
// soc_ram_sp2_ctl_if: one RAM access port (request, write data, read data and read-valid strobe)
interface soc_ram_sp2_ctl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                    en;
  logic [DATA_WIDTH/8-1:0] we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    valid;
  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/soc_ram_sp2_ctl.sv
// soc_ram_sp2_ctl: true dual-port RAM with byte enables, 1/2-cycle read latency and post-reset clear engine
module soc_ram_sp2_ctl #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DEPTH      = 2048,
  parameter int                    RD_LATENCY = 1,
  parameter int                    INIT_CLEAR = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic mclk,
  input  logic puc_rst,
  output logic init_done,
  soc_ram_sp2_ctl_if.slave a,
  soc_ram_sp2_ctl_if.slave b
);
  localparam int BE = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("soc_ram_sp2_ctl: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("soc_ram_sp2_ctl: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("soc_ram_sp2_ctl: DEPTH exceeds address space");
  end
  typedef enum logic {CLEAR, READY} state_t;
  state_t                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic                    init_done_q;
  logic                    clr_we;
  logic                    en    [2];
  logic [BE-1:0]           we    [2];
  logic [ADDR_WIDTH-1:0]   addr  [2];
  logic [DATA_WIDTH-1:0]   din   [2];
  logic [DATA_WIDTH-1:0]   dout  [2];
  logic                    valid [2];
  logic                    rd    [2];
  logic                    wr    [2];
  logic [IW-1:0]           idx   [2];
  logic [DATA_WIDTH-1:0]   mem   [DEPTH];
  assign en[0]   = a.en;
  assign we[0]   = a.we;
  assign addr[0] = a.addr;
  assign din[0]  = a.din;
  assign en[1]   = b.en;
  assign we[1]   = b.we;
  assign addr[1] = b.addr;
  assign din[1]  = b.din;
  assign a.dout  = dout[0];
  assign a.valid = valid[0];
  assign b.dout  = dout[1];
  assign b.valid = valid[1];
  assign init_done = init_done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d   = cnt_q + IW'(1);
      state_d = cnt_q == IW'(DEPTH - 1) ? READY : CLEAR;
    end
  end
  // init_done lags the READY state by one edge so ports open a full cycle after the last clear write
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q     <= INIT_CLEAR != 0 ? CLEAR : READY;
      cnt_q       <= '0;
      init_done_q <= INIT_CLEAR == 0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= state_q == READY;
    end
  end
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  inr, v1_q, v2_q;
    logic [DATA_WIDTH-1:0] d1_q, d2_q;
    assign inr    = {1'b0, addr[p]} < (ADDR_WIDTH + 1)'(DEPTH);
    assign idx[p] = addr[p][IW-1:0];
    assign rd[p]  = init_done_q && en[p] && ~|we[p];
    assign wr[p]  = init_done_q && en[p] && inr;
    always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
        d1_q <= '0;
        d2_q <= '0;
      end else begin
        v1_q <= rd[p];
        v2_q <= v1_q;
        if (rd[p]) d1_q <= inr ? mem[idx[p]] : '0;
        if (v1_q) d2_q <= d1_q;
      end
    end
    assign valid[p] = RD_LATENCY == 2 ? v2_q : v1_q;
    assign dout[p]  = RD_LATENCY == 2 ? d2_q : d1_q;
  end
  assign clr_we = state_q == CLEAR && !puc_rst;
  // Port A lanes are written last so they win a same-lane collision with port B
  always_ff @(posedge mclk) begin
    if (clr_we) mem[cnt_q] <= INIT_VALUE;
    for (int i = 0; i < BE; i++) begin
      if (wr[1] && we[1][i]) mem[idx[1]][8*i +: 8] <= din[1][8*i +: 8];
      if (wr[0] && we[0][i]) mem[idx[0]][8*i +: 8] <= din[0][8*i +: 8];
    end
  end
endmodule

// File: tb/tb_soc_ram_sp2_ctl.sv
// tb_soc_ram_sp2_ctl: drives a latency-1 and a latency-2 instance with identical vectors and checks both
module tb_soc_ram_sp2_ctl;
  typedef struct {
    logic        ae;
    logic [1:0]  awe;
    logic [4:0]  aa;
    logic [15:0] ad;
    logic        be;
    logic [1:0]  bwe;
    logic [4:0]  ba;
    logic [15:0] bd;
    logic        aev;
    logic [15:0] aed;
    logic        bev;
    logic [15:0] bed;
  } vec_t;
  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic [1:0]  a_we = '0, b_we = '0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_din = '0, b_din = '0;
  logic        done_w  [2];
  logic        valid_w [2][2];
  logic [15:0] dout_w  [2][2];
  logic        sv      [2][2][2];
  logic [15:0] sd      [2][2][2];
  logic [15:0] last_d  [2][2];
  int          n_chk = 0, n_fail = 0, step_no = 0;
  vec_t        tbl[$];
  always #5 mclk = ~mclk;
  soc_ram_sp2_ctl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) a1 (), b1 (), a2 (), b2 ();
  assign a1.en = a_en;   assign a2.en = a_en;
  assign a1.we = a_we;   assign a2.we = a_we;
  assign a1.addr = a_addr; assign a2.addr = a_addr;
  assign a1.din = a_din; assign a2.din = a_din;
  assign b1.en = b_en;   assign b2.en = b_en;
  assign b1.we = b_we;   assign b2.we = b_we;
  assign b1.addr = b_addr; assign b2.addr = b_addr;
  assign b1.din = b_din; assign b2.din = b_din;
  assign valid_w[0][0] = a1.valid; assign dout_w[0][0] = a1.dout;
  assign valid_w[0][1] = b1.valid; assign dout_w[0][1] = b1.dout;
  assign valid_w[1][0] = a2.valid; assign dout_w[1][0] = a2.dout;
  assign valid_w[1][1] = b2.valid; assign dout_w[1][1] = b2.dout;
  soc_ram_sp2_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(16), .RD_LATENCY(1),
                    .INIT_CLEAR(1), .INIT_VALUE(16'hA5A5)) u_lat1 (
    .mclk(mclk), .puc_rst(puc_rst), .init_done(done_w[0]), .a(a1), .b(b1));
  soc_ram_sp2_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(16), .RD_LATENCY(2),
                    .INIT_CLEAR(1), .INIT_VALUE(16'hA5A5)) u_lat2 (
    .mclk(mclk), .puc_rst(puc_rst), .init_done(done_w[1]), .a(a2), .b(b2));
  function automatic vec_t mk(input int ae, awe, aa, ad, be, bwe, ba, bd, aev, aed, bev, bed);
    vec_t v;
    v.ae = 1'(ae);  v.awe = 2'(awe); v.aa = 5'(aa); v.ad = 16'(ad);
    v.be = 1'(be);  v.bwe = 2'(bwe); v.ba = 5'(ba); v.bd = 16'(bd);
    v.aev = 1'(aev); v.aed = 16'(aed); v.bev = 1'(bev); v.bed = 16'(bed);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic clr_pipe();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        last_d[d][p] = '0;
        for (int k = 0; k < 2; k++) begin
          sv[d][p][k] = 1'b0;
          sd[d][p][k] = '0;
        end
      end
  endtask
  task automatic chk_quiet(input string nm);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s valid L%0d %s", nm, d + 1, p ? "B" : "A"), 16'(valid_w[d][p]), 16'h0);
        chk($sformatf("%s dout L%0d %s", nm, d + 1, p ? "B" : "A"), dout_w[d][p], 16'h0);
      end
  endtask
  task automatic chk_done(input logic exp);
    for (int d = 0; d < 2; d++)
      chk($sformatf("step%0d init_done L%0d", step_no, d + 1), 16'(done_w[d]), 16'(exp));
  endtask
  // Apply one vector at a negedge; the instance of latency L reports the read issued L-1 steps earlier
  task automatic step(input vec_t v);
    step_no++;
    a_en = v.ae; a_we = v.awe; a_addr = v.aa; a_din = v.ad;
    b_en = v.be; b_we = v.bwe; b_addr = v.ba; b_din = v.bd;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        sv[d][p][1] = sv[d][p][0];
        sd[d][p][1] = sd[d][p][0];
      end
      sv[d][0][0] = v.aev; sd[d][0][0] = v.aed;
      sv[d][1][0] = v.bev; sd[d][1][0] = v.bed;
    end
    @(posedge mclk);
    @(negedge mclk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        if (sv[d][p][d]) last_d[d][p] = sd[d][p][d];
        chk($sformatf("step%0d valid L%0d %s", step_no, d + 1, p ? "B" : "A"),
            16'(valid_w[d][p]), 16'(sv[d][p][d]));
        chk($sformatf("step%0d dout L%0d %s", step_no, d + 1, p ? "B" : "A"),
            dout_w[d][p], last_d[d][p]);
      end
  endtask
  initial begin
    logic [15:0] exp_s [8];
    exp_s = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hAB34, 16'hA5A5, 16'h1111, 16'hA5A5, 16'hF0F0};
    tbl.push_back(mk(1, 3, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 3, 16'hAB00, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 16'hAB34, 0, 0));
    tbl.push_back(mk(1, 1, 5, 16'h1111, 1, 3, 5, 16'h2222, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 1, 16'h2211, 0, 0));
    tbl.push_back(mk(1, 3, 5, 16'h1111, 1, 3, 5, 16'h2222, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 3, 7, 16'h0F0F, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 7, 16'hF0F0, 1, 0, 7, 0, 0, 0, 1, 16'h0F0F));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 1, 16'hF0F0));
    tbl.push_back(mk(1, 3, 12, 16'h1234, 1, 3, 15, 16'hC3C3, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, i, 0, 1, 0, 16, 0, 1, exp_s[i], 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 16, 16'hDEAD, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 21, 16'hBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 31, 16'h0077, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 5, 0, 1, 16'hA5A5, 1, 16'h1111));
    tbl.push_back(mk(1, 0, 15, 0, 1, 0, 12, 0, 1, 16'hC3C3, 1, 16'h1234));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr_pipe();
    repeat (2) @(negedge mclk);
    chk_quiet("reset");
    chk_done(1'b0);
    puc_rst = 1'b0;
    // Requests during the clear sweep must neither write addr 2 nor strobe valid
    for (int k = 1; k <= 17; k++) begin
      step(mk(1, 3, 2, 16'h1234, 1, 0, 2, 0, 0, 0, 0, 0));
      chk_done(k == 17);
    end
    foreach (tbl[i]) step(tbl[i]);
    a_en = 1'b1; a_we = '0; a_addr = 5'd3;
    b_en = 1'b1; b_we = '0; b_addr = 5'd5;
    @(posedge mclk);
    #1 puc_rst = 1'b1;
    a_en = 1'b0; b_en = 1'b0;
    @(negedge mclk);
    chk_quiet("flush in reset");
    puc_rst = 1'b0;
    clr_pipe();
    @(negedge mclk);
    chk_quiet("flush after release");
    repeat (9) @(negedge mclk);
    puc_rst = 1'b1;
    repeat (2) @(negedge mclk);
    puc_rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk_done(k == 17);
    end
    for (int i = 0; i < 16; i++) step(mk(1, 0, i, 0, 1, 0, 15 - i, 0, 1, 16'hA5A5, 1, 16'hA5A5));
    repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
